// File: rtl/dmi_jtag_dr.sv
// dmi_jtag_dr: TCK-domain DMI access data register and request/response FSM.
// Define DMI_JTAG_DR_TIMEOUT_EN to abort requests left unanswered for TimeoutCycles.
module dmi_jtag_dr #(
    parameter int AddrWidth     = 7,
    parameter int TimeoutCycles = 1024
) (
    input  logic                 tck_i,
    input  logic                 trst_ni,
    input  logic                 test_logic_reset_i,
    input  logic                 dmi_access_i,
    input  logic                 capture_dr_i,
    input  logic                 shift_dr_i,
    input  logic                 update_dr_i,
    input  logic                 dmi_tdi_i,
    output logic                 dmi_tdo_o,
    input  logic                 dmi_reset_i,
    output logic [1:0]           dmi_error_o,
    output logic                 dmi_req_valid_o,
    input  logic                 dmi_req_ready_i,
    output logic [AddrWidth-1:0] dmi_req_addr_o,
    output logic [1:0]           dmi_req_op_o,
    output logic [31:0]          dmi_req_data_o,
    input  logic                 dmi_resp_valid_i,
    output logic                 dmi_resp_ready_o,
    input  logic [31:0]          dmi_resp_data_i,
    input  logic [1:0]           dmi_resp_resp_i
);
    localparam int DrWidth = AddrWidth + 34;

    typedef enum logic [1:0] {Idle, Req, WaitResp} state_e;

    state_e               state_q;
    logic [DrWidth-1:0]   dr_q;
    logic [AddrWidth-1:0] addr_q, req_addr_q;
    logic [31:0]          data_q, req_data_q;
    logic [1:0]           op_q, error_q, err_set, err_next, status, dr_op;
    logic                 discard_q, busy, capture, shift, update, accept, handshake, resp_done, timeout;

    assign busy      = state_q != Idle;
    assign capture   = capture_dr_i & dmi_access_i;
    assign shift     = shift_dr_i & dmi_access_i;
    assign update    = update_dr_i & dmi_access_i;
    assign dr_op     = dr_q[1:0];
    assign accept    = update & ~busy & ~test_logic_reset_i & (error_q == 2'd0) & ((dr_op == 2'd1) | (dr_op == 2'd2));
    assign handshake = (state_q == Req) & dmi_req_ready_i;
    assign resp_done = (state_q == WaitResp) & dmi_resp_valid_i;
    assign status    = busy ? 2'd3 : error_q;

    // A response to a request issued before Test-Logic-Reset is dropped.
    always_comb begin
        err_set = 2'd0;
        if ((capture | update) & busy) err_set = 2'd3;
        else if ((resp_done & ~discard_q & (dmi_resp_resp_i != 2'd0)) | timeout) err_set = 2'd2;
        err_next = (dmi_reset_i | test_logic_reset_i) ? 2'd0 : (err_set > error_q ? err_set : error_q);
    end

`ifdef DMI_JTAG_DR_TIMEOUT_EN
    localparam int CntWidth = $clog2(TimeoutCycles + 1);

    logic [CntWidth-1:0] cnt_q;

    assign timeout = busy & (cnt_q == CntWidth'(TimeoutCycles - 1)) & ~handshake & ~resp_done;

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) cnt_q <= '0;
        else if (!busy | handshake | resp_done | timeout) cnt_q <= '0;
        else cnt_q <= cnt_q + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            state_q    <= Idle;
            dr_q       <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            req_addr_q <= '0;
            req_data_q <= '0;
            op_q       <= '0;
            error_q    <= '0;
            discard_q  <= 1'b0;
        end else begin
            error_q   <= err_next;
            discard_q <= busy & (discard_q | test_logic_reset_i);
            if (test_logic_reset_i) dr_q <= '0;
            else if (capture) dr_q <= {addr_q, data_q, status};
            else if (shift) dr_q <= {dmi_tdi_i, dr_q[DrWidth-1:1]};
            if (test_logic_reset_i) begin
                addr_q <= '0;
                data_q <= '0;
            end else if (accept) begin
                addr_q <= dr_q[DrWidth-1:34];
                data_q <= dr_q[33:2];
            end else if (resp_done & ~discard_q & (op_q == 2'd1)) begin
                data_q <= dmi_resp_data_i;
            end
            if (accept) begin
                req_addr_q <= dr_q[DrWidth-1:34];
                req_data_q <= dr_q[33:2];
                op_q       <= dr_op;
            end
            unique case (state_q)
                Idle:     if (accept) state_q <= Req;
                Req:      if (handshake) state_q <= WaitResp; else if (timeout) state_q <= Idle;
                WaitResp: if (resp_done | timeout) state_q <= Idle;
                default:  state_q <= Idle;
            endcase
        end
    end

    assign dmi_tdo_o        = dr_q[0];
    assign dmi_error_o      = error_q;
    assign dmi_req_valid_o  = state_q == Req;
    assign dmi_resp_ready_o = state_q == WaitResp;
    assign dmi_req_addr_o   = req_addr_q;
    assign dmi_req_data_o   = req_data_q;
    assign dmi_req_op_o     = op_q;
endmodule
